// File: rtl/bp_be_decode_queue.sv
// Registered RV64 decoder feeding an els_p-deep circular queue ahead of issue.
// Optional MUL/DIV decode is enabled by defining BP_BE_DECODE_MULDIV_EN.
package bp_be_decode_queue_pkg;
  localparam int rv64_instr_width_gp = 32;

  typedef enum logic [1:0] {
    e_instr_misaligned, e_instr_access_fault, e_instr_page_fault, e_itlb_miss
  } bp_fe_exception_code_e;

  typedef enum logic [5:0] {
    e_int_op_add, e_int_op_sub, e_int_op_sll, e_int_op_slt, e_int_op_sltu,
    e_int_op_xor, e_int_op_srl, e_int_op_sra, e_int_op_or, e_int_op_and,
    e_int_op_pass_src2, e_int_op_eq, e_int_op_ne, e_int_op_sge, e_int_op_sgeu,
    e_lb, e_lh, e_lw, e_ld, e_lbu, e_lhu, e_lwu, e_sb, e_sh, e_sw, e_sd,
    e_lrw, e_scw, e_lrd, e_scd, e_fencei,
    e_csrrw, e_csrrs, e_csrrc, e_csrrwi, e_csrrsi, e_csrrci,
    e_ecall, e_ebreak, e_mret, e_sret, e_wfi, e_sfence_vma,
    e_op_illegal_instr, e_itlb_fill, e_op_instr_misaligned,
    e_op_instr_access_fault, e_op_instr_page_fault,
    e_mul_op_mul, e_mul_op_mulh, e_mul_op_mulhsu, e_mul_op_mulhu,
    e_mul_op_div, e_mul_op_divu, e_mul_op_rem, e_mul_op_remu
  } bp_be_fu_op_e;

  typedef enum logic {e_src1_is_rs1, e_src1_is_pc} bp_be_src1_e;
  typedef enum logic {e_src2_is_rs2, e_src2_is_imm} bp_be_src2_e;
  typedef enum logic {e_baddr_is_pc, e_baddr_is_rs1} bp_be_baddr_e;
  typedef enum logic {e_result_from_alu, e_result_from_pc_plus4} bp_be_result_e;
  typedef enum logic {e_offset_is_imm, e_offset_is_zero} bp_be_offset_e;

  typedef struct packed {
    logic queue_v, instr_v;
    logic pipe_int_v, pipe_mem_v, pipe_mul_v, pipe_comp_v;
    logic irf_w_v, opw_v, br_v, jmp_v;
    logic mem_v, dcache_r_v, dcache_w_v;
    logic csr_v, csr_r_v, csr_w_v, serial_v;
    bp_be_src1_e   src1_sel;
    bp_be_src2_e   src2_sel;
    bp_be_baddr_e  baddr_sel;
    bp_be_result_e result_sel;
    bp_be_offset_e offset_sel;
    bp_be_fu_op_e  fu_op;
  } bp_be_decode_s;

  localparam int bp_be_decode_width = $bits(bp_be_decode_s);
endpackage

module bp_be_decode_queue
  import bp_be_decode_queue_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int els_p         = 2,
  parameter int count_width_p = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic                           instr_v_i,
  output logic                           instr_ready_o,
  input  logic                           fe_exc_not_instr_i,
  input  bp_fe_exception_code_e          fe_exc_i,
  input  logic [rv64_instr_width_gp-1:0] instr_i,
  input  logic [vaddr_width_p-1:0]       pc_i,
  output logic                           decode_v_o,
  input  logic                           decode_yumi_i,
  output logic [bp_be_decode_width-1:0]  decode_o,
  output logic [vaddr_width_p-1:0]       pc_o,
  output logic [count_width_p-1:0]       illegal_count_o
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  localparam logic [6:0] op_c = 7'b0110011, op_32_c = 7'b0111011, op_imm_c = 7'b0010011,
    op_imm_32_c = 7'b0011011, lui_c = 7'b0110111, auipc_c = 7'b0010111, jal_c = 7'b1101111,
    jalr_c = 7'b1100111, branch_c = 7'b1100011, load_c = 7'b0000011, store_c = 7'b0100011,
    misc_mem_c = 7'b0001111, system_c = 7'b1110011, amo_c = 7'b0101111;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       is_imm;
  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign is_imm = (opcode == op_imm_c) || (opcode == op_imm_32_c);

  bp_be_decode_s dec;
  logic          illegal;

  always_comb begin
    dec            = '0;
    dec.queue_v    = 1'b1;
    dec.instr_v    = 1'b1;
    dec.offset_sel = e_offset_is_imm;
    illegal        = 1'b0;
    case (opcode)
      op_c, op_32_c, op_imm_c, op_imm_32_c: begin
        dec.pipe_int_v = 1'b1;
        dec.irf_w_v    = 1'b1;
        dec.opw_v      = (opcode == op_32_c) || (opcode == op_imm_32_c);
        dec.src2_sel   = is_imm ? e_src2_is_imm : e_src2_is_rs2;
        case (f3)
          3'b000: dec.fu_op = (!is_imm && instr_i[30]) ? e_int_op_sub : e_int_op_add;
          3'b001: dec.fu_op = e_int_op_sll;
          3'b010: dec.fu_op = e_int_op_slt;
          3'b011: dec.fu_op = e_int_op_sltu;
          3'b100: dec.fu_op = e_int_op_xor;
          3'b101: dec.fu_op = instr_i[30] ? e_int_op_sra : e_int_op_srl;
          3'b110: dec.fu_op = e_int_op_or;
          3'b111: dec.fu_op = e_int_op_and;
        endcase
        if (dec.opw_v && !(f3 inside {3'b000, 3'b001, 3'b101})) illegal = 1'b1;
        // Immediates only constrain funct7 on shifts; the W forms have a 5-bit shamt.
        if (!is_imm) begin
          if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
            illegal = 1'b1;
        end else if (f3 == 3'b001) begin
          if (instr_i[31:26] != 6'b0 || (dec.opw_v && instr_i[25])) illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          if ({instr_i[31], instr_i[29:26]} != 5'b0 || (dec.opw_v && instr_i[25])) illegal = 1'b1;
        end
`ifdef BP_BE_DECODE_MULDIV_EN
        if (!is_imm && f7 == 7'b0000001) begin
          dec.pipe_int_v = 1'b0;
          dec.pipe_mul_v = 1'b1;
          case (f3)
            3'b000: dec.fu_op = e_mul_op_mul;
            3'b001: dec.fu_op = e_mul_op_mulh;
            3'b010: dec.fu_op = e_mul_op_mulhsu;
            3'b011: dec.fu_op = e_mul_op_mulhu;
            3'b100: dec.fu_op = e_mul_op_div;
            3'b101: dec.fu_op = e_mul_op_divu;
            3'b110: dec.fu_op = e_mul_op_rem;
            3'b111: dec.fu_op = e_mul_op_remu;
          endcase
          illegal = dec.opw_v && (f3 inside {3'b001, 3'b010, 3'b011});
        end
`endif
      end
      lui_c: begin
        dec.pipe_int_v = 1'b1; dec.irf_w_v = 1'b1;
        dec.src2_sel = e_src2_is_imm; dec.fu_op = e_int_op_pass_src2;
      end
      auipc_c: begin
        dec.pipe_int_v = 1'b1; dec.irf_w_v = 1'b1;
        dec.src1_sel = e_src1_is_pc; dec.src2_sel = e_src2_is_imm; dec.fu_op = e_int_op_add;
      end
      jal_c, jalr_c: begin
        dec.pipe_int_v = 1'b1; dec.irf_w_v = 1'b1; dec.jmp_v = 1'b1;
        dec.result_sel = e_result_from_pc_plus4;
        dec.baddr_sel  = (opcode == jalr_c) ? e_baddr_is_rs1 : e_baddr_is_pc;
        if (opcode == jalr_c && f3 != 3'b000) illegal = 1'b1;
      end
      branch_c: begin
        dec.pipe_int_v = 1'b1; dec.br_v = 1'b1; dec.baddr_sel = e_baddr_is_pc;
        case (f3)
          3'b000:  dec.fu_op = e_int_op_eq;
          3'b001:  dec.fu_op = e_int_op_ne;
          3'b100:  dec.fu_op = e_int_op_slt;
          3'b101:  dec.fu_op = e_int_op_sge;
          3'b110:  dec.fu_op = e_int_op_sltu;
          3'b111:  dec.fu_op = e_int_op_sgeu;
          default: illegal = 1'b1;
        endcase
      end
      load_c: begin
        dec.pipe_mem_v = 1'b1; dec.mem_v = 1'b1; dec.dcache_r_v = 1'b1; dec.irf_w_v = 1'b1;
        case (f3)
          3'b000:  dec.fu_op = e_lb;
          3'b001:  dec.fu_op = e_lh;
          3'b010:  dec.fu_op = e_lw;
          3'b011:  dec.fu_op = e_ld;
          3'b100:  dec.fu_op = e_lbu;
          3'b101:  dec.fu_op = e_lhu;
          3'b110:  dec.fu_op = e_lwu;
          default: illegal = 1'b1;
        endcase
      end
      store_c: begin
        dec.pipe_mem_v = 1'b1; dec.mem_v = 1'b1; dec.dcache_w_v = 1'b1;
        case (f3)
          3'b000:  dec.fu_op = e_sb;
          3'b001:  dec.fu_op = e_sh;
          3'b010:  dec.fu_op = e_sw;
          3'b011:  dec.fu_op = e_sd;
          default: illegal = 1'b1;
        endcase
      end
      misc_mem_c: begin
        if (f3 == 3'b000) dec.pipe_comp_v = 1'b1;
        else if (f3 == 3'b001) begin
          dec.pipe_mem_v = 1'b1; dec.dcache_w_v = 1'b1; dec.serial_v = 1'b1; dec.fu_op = e_fencei;
        end else illegal = 1'b1;
      end
      system_c: begin
        dec.pipe_mem_v = 1'b1; dec.csr_v = 1'b1; dec.serial_v = 1'b1;
        if (f3 == 3'b000) begin
          case (instr_i)
            32'h00000073: dec.fu_op = e_ecall;
            32'h00100073: dec.fu_op = e_ebreak;
            32'h30200073: dec.fu_op = e_mret;
            32'h10200073: dec.fu_op = e_sret;
            32'h10500073: dec.fu_op = e_wfi;
            default:
              if (f7 == 7'b0001001 && instr_i[11:7] == 5'b0) dec.fu_op = e_sfence_vma;
              else illegal = 1'b1;
          endcase
        end else begin
          dec.irf_w_v = 1'b1; dec.csr_r_v = 1'b1; dec.csr_w_v = 1'b1;
          case (f3)
            3'b001:  dec.fu_op = e_csrrw;
            3'b010:  dec.fu_op = e_csrrs;
            3'b011:  dec.fu_op = e_csrrc;
            3'b101:  dec.fu_op = e_csrrwi;
            3'b110:  dec.fu_op = e_csrrsi;
            3'b111:  dec.fu_op = e_csrrci;
            default: illegal = 1'b1;
          endcase
        end
      end
      amo_c: begin
        dec.pipe_mem_v = 1'b1; dec.mem_v = 1'b1; dec.dcache_r_v = 1'b1; dec.dcache_w_v = 1'b1;
        dec.irf_w_v = 1'b1; dec.offset_sel = e_offset_is_zero;
        if (f3 == 3'b010 && instr_i[31:27] == 5'b00010 && instr_i[24:20] == 5'b0) dec.fu_op = e_lrw;
        else if (f3 == 3'b010 && instr_i[31:27] == 5'b00011) dec.fu_op = e_scw;
        else if (f3 == 3'b011 && instr_i[31:27] == 5'b00010 && instr_i[24:20] == 5'b0) dec.fu_op = e_lrd;
        else if (f3 == 3'b011 && instr_i[31:27] == 5'b00011) dec.fu_op = e_scd;
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // Exceptions and illegals travel as serialized mem-pipe ops carrying only their cause.
    if (fe_exc_not_instr_i || illegal) begin
      dec            = '0;
      dec.queue_v    = 1'b1;
      dec.pipe_mem_v = 1'b1;
      dec.csr_v      = 1'b1;
      dec.serial_v   = 1'b1;
      if (!fe_exc_not_instr_i) dec.fu_op = e_op_illegal_instr;
      else case (fe_exc_i)
        e_instr_misaligned:   dec.fu_op = e_op_instr_misaligned;
        e_instr_access_fault: dec.fu_op = e_op_instr_access_fault;
        e_instr_page_fault:   dec.fu_op = e_op_instr_page_fault;
        default:              dec.fu_op = e_itlb_fill;
      endcase
    end
  end

  bp_be_decode_s            dq_mem [els_p];
  logic [vaddr_width_p-1:0] pc_mem [els_p];
  logic [ptr_w-1:0]         rptr, wptr;
  logic [cnt_w-1:0]         count;
  logic                     enq, deq;

  assign instr_ready_o = (count != cnt_w'(els_p)) & ~reset_i;
  assign decode_v_o    = (count != '0);
  assign enq           = instr_v_i & instr_ready_o & ~flush_i;
  assign deq           = decode_yumi_i & decode_v_o & ~flush_i;
  assign decode_o      = dq_mem[rptr];
  assign pc_o          = pc_mem[rptr];

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + ptr_w'(1);
      if (deq) rptr <= rptr + ptr_w'(1);
      if (enq && !deq) count <= count + cnt_w'(1);
      else if (deq && !enq) count <= count - cnt_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      dq_mem[wptr] <= dec;
      pc_mem[wptr] <= pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) illegal_count_o <= '0;
    else if (enq && illegal && !fe_exc_not_instr_i && !(&illegal_count_o))
      illegal_count_o <= illegal_count_o + count_width_p'(1);
  end
endmodule

// File: doc/bp_be_decode_queue.md
# bp_be_decode_queue

Registered, buffered successor to the backend's combinational RV64 instruction decoder. It accepts one fetched instruction (or front-end exception) per cycle under a valid/ready handshake, decodes it into `bp_be_decode_s`, and holds decoded entries with their PCs in an `els_p`-deep circular queue ahead of the issue stage. It adds flush, back-pressure, an illegal-instruction counter and optional M-extension decode.

## Interface
- `vaddr_width_p`, 39, width of the PC carried with each entry
- `els_p`, 2, queue depth; power of two, ≥2
- `count_width_p`, 16, width of the illegal-instruction counter
- `clk_i`  in  1  clock; all state updates on the rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `flush_i`  in  1  discard all queued entries
- `instr_v_i`  in  1  input valid
- `instr_ready_o`  out  1  input ready; enqueue when `instr_v_i & instr_ready_o & ~flush_i`
- `fe_exc_not_instr_i`  in  1  entry is a front-end exception, not an instruction
- `fe_exc_i`  in  `bp_fe_exception_code_e`  exception code
- `instr_i`  in  `rv64_instr_width_gp`  raw instruction
- `pc_i`  in  `vaddr_width_p`  instruction PC
- `decode_v_o`  out  1  head entry valid
- `decode_yumi_i`  in  1  consumer takes the head; legal only when `decode_v_o`
- `decode_o`  out  `bp_be_decode_width`  head decode
- `pc_o`  out  `vaddr_width_p`  head PC
- `illegal_count_o`  out  `count_width_p`  saturating illegal-instruction count

## Operation
- Decode is combinational on the input side. Only the result is written into the queue, never the raw instruction.
- Defaults for every decode: all fields 0, `queue_v=1`, `instr_v=1`, `offset_sel=e_offset_is_imm`.
- OP/OP_32: `pipe_int_v`, `irf_w_v`, rs1/rs2, ALU result; `opw_v` set for the `_32` opcode.
- OP_IMM/OP_IMM_32: as above, with `src2=imm`.
- LUI uses `pass_src2`. AUIPC adds with `src1=pc`.
- JAL/JALR: `jmp_v`, result from PC+4; `baddr` is pc or rs1 respectively.
- BRANCH: `br_v`, compare ops eq/ne/slt/sge/sltu/sgeu.
- LOAD/STORE: `pipe_mem_v`, `mem_v`, `dcache_r_v`/`dcache_w_v`, and the width-specific `fu_op`.
- FENCE goes to `pipe_comp_v`. FENCE.I: mem pipe, `dcache_w_v`, `serial_v`, `e_fencei`.
- SYSTEM: mem pipe, `csr_v`, `serial_v`. Privileged ops map to their own `fu_op`. CSR ops also set `irf_w_v`, `csr_r_v`, `csr_w_v`.
- AMO (LR/SC W/D): mem pipe, read and write, `offset_sel=e_offset_is_zero`.
- Any unmatched encoding is illegal.
- Priority: `fe_exc_not_instr_i` > illegal > normal.
  - Exception and illegal entries are zeroed except `queue_v`, `pipe_mem_v`, `csr_v`, `serial_v`.
  - `fu_op` is taken from the exception code, or is `e_op_illegal_instr`.
- Queue state: read pointer, write pointer, and count (0..`els_p`); pointers wrap modulo `els_p`.
  - `instr_ready_o = (count != els_p) & ~reset_i`.
  - `decode_v_o = (count != 0)`.
  - Simultaneous enqueue and dequeue leaves count unchanged. A full queue plus yumi still deasserts ready that cycle, because ready does not depend on yumi.
- `flush_i`: count and both pointers return to 0 next cycle.
  - An enqueue or yumi in the same cycle is ignored; flush wins.
  - `illegal_count_o` is unaffected by flush.
- Illegal counter: +1 per accepted entry that is illegal and not a front-end exception. It saturates at all-ones and is cleared only by reset.

## Timing
- Reset (sync): count=0, pointers=0, `decode_v_o=0`, `illegal_count_o=0`, `instr_ready_o=0` while `reset_i` is high and 1 the cycle after.
- Latency: an entry accepted in cycle t is visible on `decode_o`/`pc_o` with `decode_v_o=1` in cycle t+1. There is no same-cycle bypass.
- Throughput: one entry per cycle, sustained indefinitely when yumi is asserted every cycle.
- `decode_o`/`pc_o` hold stable while `decode_v_o=1` and no yumi is given. They are don't-care when `decode_v_o=0`.
- Reset asserted mid-stream discards all entries and overrides flush and handshakes.

## Configuration
- `BP_BE_DECODE_MULDIV_EN` defined: OP/OP_32 with funct7=`0000001` decode as follows.
  - Common to all: `pipe_mul_v`, `irf_w_v`, rs1/rs2.
  - `fu_op` is `e_mul_op_{mul,mulh,mulhsu,mulhu,div,divu,rem,remu}` by funct3.
  - W forms set `opw_v`. MULH* with OP_32 is illegal.
- Not defined: all funct7=`0000001` encodings are illegal, and no `pipe_mul_v` logic is generated.

## Test plan
- `ADD x1,x2,x3` (0x003100B3, pc 0x80000000) accepted at t -> at t+1: `decode_v_o=1`, `pipe_int_v=1`, `irf_w_v=1`, `fu_op=e_int_op_add`, `pc_o=0x80000000`.
- `instr_i=0x00000000` -> `fu_op=e_op_illegal_instr`, `pipe_mem_v=1`, `serial_v=1`; `illegal_count_o` 0->1. Same input with `fe_exc_not_instr_i=1`, `e_itlb_miss` -> `e_itlb_fill`, counter unchanged.
- `els_p=2`, 3 back-to-back pushes, no yumi -> `instr_ready_o=0` after the 2nd accept. The 3rd is stalled and accepted only in the cycle after the first yumi; output order is preserved.
- 2 entries queued, `flush_i` with a simultaneous push and yumi -> next cycle `decode_v_o=0` and `instr_ready_o=1`; the pushed entry never appears.
- `count_width_p=2`, 5 illegal instructions -> `illegal_count_o` = 1,2,3,3,3. Reset -> 0.
- `MUL x1,x2,x3` (0x023100B3) -> with the macro: `pipe_mul_v=1`, `fu_op=e_mul_op_mul`. Without the macro: illegal entry, counter +1.
